// File: rtl/seg7_numeric_driver.sv
// Binary-to-7-segment display driver: iterative shift-add-3 decimal conversion or direct hex
// digits, with leading-zero blanking, per-digit decimal points and overflow dashes.
module seg7_numeric_driver #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned DIGITS     = 6,
    parameter int unsigned ACTIVE_LOW = 1
) (
    input  logic                  iCLK,
    input  logic                  iRST,
    input  logic [WIDTH-1:0]      iVALUE,
    input  logic                  iLOAD,
    input  logic                  iHEX_MODE,
    input  logic                  iBLANK_LZ,
    input  logic [DIGITS-1:0]     iDP,
    output logic                  oREADY,
    output logic                  oDONE,
    output logic                  oOVF,
    output logic [8*DIGITS-1:0]   oSEG
);

    localparam int BcdW = 4 * int'(DIGITS);
    localparam int SegW = 8 * int'(DIGITS);
    localparam int PadW = (int'(WIDTH) > BcdW) ? int'(WIDTH) : BcdW;
    localparam int CntW = $clog2(WIDTH);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StShift = 2'd1;
    localparam logic [1:0] StLatch = 2'd2;

    localparam logic [SegW-1:0] SegOff = (ACTIVE_LOW != 0) ? {SegW{1'b1}} : {SegW{1'b0}};

    // Active-high g..a patterns for one hex digit.
    function automatic logic [6:0] hex7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'h0:    s = 7'b0111111;
            4'h1:    s = 7'b0000110;
            4'h2:    s = 7'b1011011;
            4'h3:    s = 7'b1001111;
            4'h4:    s = 7'b1100110;
            4'h5:    s = 7'b1101101;
            4'h6:    s = 7'b1111101;
            4'h7:    s = 7'b0000111;
            4'h8:    s = 7'b1111111;
            4'h9:    s = 7'b1101111;
            4'hA:    s = 7'b1110111;
            4'hB:    s = 7'b1111100;
            4'hC:    s = 7'b0111001;
            4'hD:    s = 7'b1011110;
            4'hE:    s = 7'b1111001;
            default: s = 7'b1110001;
        endcase
        return s;
    endfunction

    logic [1:0]        state_q, state_d;
    logic [WIDTH-1:0]  value_q, value_d;
    logic [BcdW-1:0]   bcd_q, bcd_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              sticky_q, sticky_d;
    logic              hex_q, hex_d;
    logic              blank_q, blank_d;
    logic [DIGITS-1:0] dp_q, dp_d;
    logic [SegW-1:0]   seg_q, seg_d;
    logic              ovf_q, ovf_d;
    logic              done_q, done_d;

    logic [BcdW-1:0]   bcd_adj;
    logic [PadW-1:0]   hex_pad;
    logic              hex_ovf;
    logic              ovf_now;
    logic [BcdW-1:0]   digit_src;
    logic [SegW-1:0]   seg_hi;
    logic [SegW-1:0]   seg_new;
    logic [3:0]        nib;
    logic [7:0]        dig_byte;
    logic              higher_zero;

    // Shift-add-3 correction applied before each shift.
    always_comb begin
        bcd_adj = bcd_q;
        for (int k = 0; k < int'(DIGITS); k++) begin
            if (bcd_q[4*k +: 4] >= 4'd5) begin
                bcd_adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
            end
        end
    end

    // Hex digits come straight from the captured value, zero-extended to the display width.
    always_comb begin
        hex_pad = '0;
        hex_pad[WIDTH-1:0] = value_q;
        hex_ovf = 1'b0;
        for (int i = BcdW; i < PadW; i++) begin
            hex_ovf = hex_ovf | hex_pad[i];
        end
    end

    assign ovf_now   = hex_q ? hex_ovf : sticky_q;
    assign digit_src = hex_q ? hex_pad[BcdW-1:0] : bcd_q;

    // Walk from the most significant digit so blanking knows whether everything above is zero.
    always_comb begin
        seg_hi      = '0;
        nib         = 4'd0;
        dig_byte    = 8'd0;
        higher_zero = 1'b1;
        for (int k = int'(DIGITS) - 1; k >= 0; k--) begin
            nib         = digit_src[4*k +: 4];
            higher_zero = higher_zero & (nib == 4'd0);
            if (ovf_now) begin
                dig_byte = {dp_q[k], 7'b1000000};
            end else if (blank_q && higher_zero && (k != 0)) begin
                dig_byte = 8'h00;
            end else begin
                dig_byte = {dp_q[k], hex7(nib)};
            end
            seg_hi[8*k +: 8] = dig_byte;
        end
        seg_new = (ACTIVE_LOW != 0) ? ~seg_hi : seg_hi;
    end

    always_comb begin
        state_d  = state_q;
        value_d  = value_q;
        bcd_d    = bcd_q;
        cnt_d    = cnt_q;
        sticky_d = sticky_q;
        hex_d    = hex_q;
        blank_d  = blank_q;
        dp_d     = dp_q;
        seg_d    = seg_q;
        ovf_d    = ovf_q;
        done_d   = 1'b0;
        case (state_q)
            StIdle: begin
                if (iLOAD) begin
                    value_d  = iVALUE;
                    hex_d    = iHEX_MODE;
                    blank_d  = iBLANK_LZ;
                    dp_d     = iDP;
                    bcd_d    = '0;
                    sticky_d = 1'b0;
                    cnt_d    = CntW'(WIDTH - 1);
                    state_d  = iHEX_MODE ? StLatch : StShift;
                end
            end
            StShift: begin
                bcd_d   = {bcd_adj[BcdW-2:0], value_q[WIDTH-1]};
                value_d = {value_q[WIDTH-2:0], 1'b0};
                // A one leaving the top digit means the value needs more digits than we have.
                if (bcd_adj[BcdW-1]) begin
                    sticky_d = 1'b1;
                end
                if (cnt_q == '0) begin
                    state_d = StLatch;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StLatch: begin
                seg_d   = seg_new;
                ovf_d   = ovf_now;
                done_d  = 1'b1;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_q  <= StIdle;
            value_q  <= '0;
            bcd_q    <= '0;
            cnt_q    <= '0;
            sticky_q <= 1'b0;
            hex_q    <= 1'b0;
            blank_q  <= 1'b0;
            dp_q     <= '0;
            seg_q    <= SegOff;
            ovf_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            value_q  <= value_d;
            bcd_q    <= bcd_d;
            cnt_q    <= cnt_d;
            sticky_q <= sticky_d;
            hex_q    <= hex_d;
            blank_q  <= blank_d;
            dp_q     <= dp_d;
            seg_q    <= seg_d;
            ovf_q    <= ovf_d;
            done_q   <= done_d;
        end
    end

    assign oREADY = (state_q == StIdle);
    assign oDONE  = done_q;
    assign oOVF   = ovf_q;
    assign oSEG   = seg_q;

endmodule

// File: tb/tb_seg7_numeric_driver.sv
// Directed bench for seg7_numeric_driver: a vector table of loads plus reset, busy and
// back-to-back handshake sequences.
module tb_seg7_numeric_driver;

    localparam int WIDTH  = 32;
    localparam int DIGITS = 6;
    localparam logic [47:0] ALL_OFF = {48{1'b1}};

    logic        clk = 1'b0;
    logic        iRST = 1'b1;
    logic [31:0] iVALUE = '0;
    logic        iLOAD = 1'b0;
    logic        iHEX_MODE = 1'b0;
    logic        iBLANK_LZ = 1'b0;
    logic [5:0]  iDP = '0;
    logic        oREADY;
    logic        oDONE;
    logic        oOVF;
    logic [47:0] oSEG;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seg7_numeric_driver #(
        .WIDTH      (WIDTH),
        .DIGITS     (DIGITS),
        .ACTIVE_LOW (1)
    ) dut (
        .iCLK      (clk),
        .iRST      (iRST),
        .iVALUE    (iVALUE),
        .iLOAD     (iLOAD),
        .iHEX_MODE (iHEX_MODE),
        .iBLANK_LZ (iBLANK_LZ),
        .iDP       (iDP),
        .oREADY    (oREADY),
        .oDONE     (oDONE),
        .oOVF      (oOVF),
        .oSEG      (oSEG)
    );

    typedef struct {
        logic [31:0] value;
        logic        hex;
        logic        blz;
        logic [5:0]  dp;
        logic [47:0] seg;
        logic        ovf;
        int          lat;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Presents a load at a negedge, lets it be accepted, then scrambles the inputs.
    // Returns at the negedge of cycle T+1.
    task automatic start_load(input logic [31:0] v, input logic hex, input logic blz,
                              input logic [5:0] dp);
        @(negedge clk);
        check("ready before load", {63'd0, oREADY}, 64'd1);
        iVALUE = v; iHEX_MODE = hex; iBLANK_LZ = blz; iDP = dp; iLOAD = 1'b1;
        @(posedge clk);
        @(negedge clk);
        iLOAD = 1'b0; iVALUE = ~v; iHEX_MODE = ~hex; iBLANK_LZ = ~blz; iDP = ~dp;
    endtask

    // Waits (bounded) for oDONE; lat is the cycle offset from the accept cycle, -1 on timeout.
    task automatic wait_done(input int start, output int lat, output bit ready_ok);
        lat = start;
        ready_ok = 1'b1;
        while (!oDONE && lat < 100) begin
            if (oREADY) ready_ok = 1'b0;
            @(negedge clk);
            lat++;
        end
        if (!oDONE) lat = -1;
        if (!oREADY) ready_ok = 1'b0;
    endtask

    task automatic count_done(input int cycles, output int n);
        n = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (oDONE) n++;
        end
    endtask

    initial begin
        int  lat;
        bit  rdy;
        int  n;

        vecs[0]  = '{32'd1234,       1'b0, 1'b0, 6'b000000, 48'hC0C0_F9A4_B099, 1'b0, 34};
        vecs[1]  = '{32'd0,          1'b0, 1'b1, 6'b000000, 48'hFFFF_FFFF_FFC0, 1'b0, 34};
        vecs[2]  = '{32'd1000,       1'b0, 1'b1, 6'b000000, 48'hFFFF_F9C0_C0C0, 1'b0, 34};
        vecs[3]  = '{32'h0000BEEF,   1'b1, 1'b0, 6'b000001, 48'hC0C0_8386_860E, 1'b0, 2};
        vecs[4]  = '{32'd1000000,    1'b0, 1'b0, 6'b000000, 48'hBFBF_BFBF_BFBF, 1'b1, 34};
        vecs[5]  = '{32'd999999,     1'b0, 1'b0, 6'b000000, 48'h9090_9090_9090, 1'b0, 34};
        vecs[6]  = '{32'h12345678,   1'b1, 1'b0, 6'b000000, 48'hBFBF_BFBF_BFBF, 1'b1, 2};
        vecs[7]  = '{32'h00ABCDEF,   1'b1, 1'b1, 6'b100000, 48'h0883_C6A1_868E, 1'b0, 2};
        vecs[8]  = '{32'd42,         1'b0, 1'b1, 6'b100010, 48'hFFFF_FFFF_19A4, 1'b0, 34};
        vecs[9]  = '{32'h00000000,   1'b1, 1'b1, 6'b000000, 48'hFFFF_FFFF_FFC0, 1'b0, 2};
        vecs[10] = '{32'hFFFFFFFF,   1'b0, 1'b1, 6'b010101, 48'hBF3F_BF3F_BF3F, 1'b1, 34};
        vecs[11] = '{32'd100000,     1'b0, 1'b1, 6'b000000, 48'hF9C0_C0C0_C0C0, 1'b0, 34};
        vecs[12] = '{32'h00000100,   1'b1, 1'b1, 6'b000000, 48'hFFFF_FFF9_C0C0, 1'b0, 2};

        // Reset with a simultaneous load request: reset must win.
        iLOAD = 1'b1; iVALUE = 32'd5;
        repeat (3) @(negedge clk);
        iRST = 1'b0; iLOAD = 1'b0;
        check("reset ready", {63'd0, oREADY}, 64'd1);
        check("reset done", {63'd0, oDONE}, 64'd0);
        check("reset ovf", {63'd0, oOVF}, 64'd0);
        check("reset seg", {16'd0, oSEG}, {16'd0, ALL_OFF});

        foreach (vecs[i]) begin
            start_load(vecs[i].value, vecs[i].hex, vecs[i].blz, vecs[i].dp);
            wait_done(1, lat, rdy);
            check($sformatf("vec%0d latency", i), 64'(lat), 64'(vecs[i].lat));
            check($sformatf("vec%0d seg", i), {16'd0, oSEG}, {16'd0, vecs[i].seg});
            check($sformatf("vec%0d ovf", i), {63'd0, oOVF}, {63'd0, vecs[i].ovf});
            check($sformatf("vec%0d ready", i), {63'd0, rdy}, 64'd1);
        end

        // Reset in the middle of a decimal conversion.
        start_load(32'd42, 1'b0, 1'b0, 6'b000000);
        repeat (9) @(negedge clk);
        iRST = 1'b1; iLOAD = 1'b1; iVALUE = 32'd7;
        @(negedge clk);
        iRST = 1'b0; iLOAD = 1'b0;
        check("midreset ready", {63'd0, oREADY}, 64'd1);
        check("midreset seg", {16'd0, oSEG}, {16'd0, ALL_OFF});
        check("midreset ovf", {63'd0, oOVF}, 64'd0);
        count_done(40, n);
        check("midreset no done", 64'(n), 64'd0);
        start_load(32'd42, 1'b0, 1'b0, 6'b000000);
        wait_done(1, lat, rdy);
        check("after reset latency", 64'(lat), 64'd34);
        check("after reset seg", {16'd0, oSEG}, 64'h0000_C0C0_C0C0_99A4);

        // Load request while busy is dropped, not queued.
        start_load(32'd1234, 1'b0, 1'b0, 6'b000000);
        repeat (4) @(negedge clk);
        iLOAD = 1'b1; iVALUE = 32'd777;
        @(negedge clk);
        iLOAD = 1'b0;
        wait_done(6, lat, rdy);
        check("busy latency", 64'(lat), 64'd34);
        check("busy seg", {16'd0, oSEG}, 64'h0000_C0C0_F9A4_B099);
        check("busy ready", {63'd0, rdy}, 64'd1);
        count_done(40, n);
        check("busy no queued", 64'(n), 64'd0);

        // iLOAD held high: the second load is taken in the oDONE cycle.
        @(negedge clk);
        iVALUE = 32'h5; iHEX_MODE = 1'b1; iBLANK_LZ = 1'b0; iDP = '0; iLOAD = 1'b1;
        @(posedge clk);
        @(negedge clk);
        iVALUE = 32'hA;
        wait_done(1, lat, rdy);
        check("b2b first latency", 64'(lat), 64'd2);
        check("b2b first seg", {16'd0, oSEG}, 64'h0000_C0C0_C0C0_C092);
        check("b2b first ready", {63'd0, oREADY}, 64'd1);
        @(negedge clk);
        iLOAD = 1'b0;
        check("b2b busy", {63'd0, oREADY}, 64'd0);
        @(negedge clk);
        check("b2b second done", {63'd0, oDONE}, 64'd1);
        check("b2b second seg", {16'd0, oSEG}, 64'h0000_C0C0_C0C0_C088);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg7_numeric_driver.md
Name: seg7_numeric_driver

Overview:
- Parametrised, sequential successor to the fixed single-digit 7-segment decoder.
- Converts a WIDTH-bit binary value to DIGITS display digits, in decimal or hex, with a load/ready/done handshake.
- Decimal conversion is iterative (shift-add-3, one bit per clock), replacing the per-digit divide/modulo logic. Optional leading-zero blanking, per-digit decimal points, and an overflow indication.
- Sits between the processor status counters (cycle count, PC) and the board HEX outputs.

Parameters:
- WIDTH, 32, binary input width (>=4).
- DIGITS, 6, number of display digits driven (1..8).
- ACTIVE_LOW, 1, 1 = segment on when bit is 0 (board polarity); 0 = segment on when bit is 1.

Ports:
- iCLK  in  1  clock.
- iRST  in  1  synchronous reset, active-high.
- iVALUE  in  WIDTH  binary value to display; sampled on accepted load.
- iLOAD  in  1  load request; accepted only when oREADY=1.
- iHEX_MODE  in  1  1 = hex digits, 0 = decimal; sampled on accepted load.
- iBLANK_LZ  in  1  1 = blank leading zeros; sampled on accepted load.
- iDP  in  DIGITS  decimal-point enable per digit; sampled on accepted load.
- oREADY  out  1  high in IDLE only.
- oDONE  out  1  one-cycle pulse, coincident with the first cycle oSEG shows the new value.
- oOVF  out  1  registered; value did not fit in DIGITS digits. Held until next update.
- oSEG  out  8*DIGITS  digit k in bits [8k+7:8k]; bit order {dp,g,f,e,d,c,b,a}; digit 0 = least significant.

Behaviour:
- Reset:
  - State IDLE; oREADY=1; oDONE=0; oOVF=0.
  - oSEG all segments off (all ones if ACTIVE_LOW, all zeros otherwise).
  - Reset mid-conversion aborts the conversion with no oDONE pulse.
- FSM states:
  - IDLE: iLOAD=1 at cycle T captures iVALUE, iHEX_MODE, iBLANK_LZ, iDP, and clears the internal BCD register and sticky overflow. Next state is SHIFT (decimal) or LATCH (hex).
  - SHIFT: exactly WIDTH cycles, bit counter from WIDTH-1 down to 0. Each cycle:
    - add 3 to every BCD digit >=5;
    - shift {BCD, value} left by 1.
    - If the bit shifted out of the top BCD digit is 1, set sticky overflow.
    - BCD register is 4*DIGITS bits.
    - After the last bit, go to LATCH.
  - LATCH: one cycle. Compute the digit codes, then register oSEG and oOVF and assert oDONE on the next edge. Return to IDLE.
- Hex overflow: any bit of iVALUE above 4*DIGITS-1 set (none if WIDTH <= 4*DIGITS). Digits above the width are zero.
- Latency (accept cycle T):
  - Decimal: oDONE high in cycle T+WIDTH+2.
  - Hex: oDONE high in cycle T+2.
  - oREADY is low from T+1 until oDONE is asserted, and high again in the oDONE cycle.
- Encoding: active-high patterns g..a are the inverses of the team's existing table (0 -> 0111111, 1 -> 0000110, ..., F -> 1110001). The dp bit equals iDP[k]. The whole byte is inverted when ACTIVE_LOW=1.
- Leading-zero blanking (iBLANK_LZ=1): digit k is blanked (all segments off, dp included) if it and all higher digits are zero, for k>0. Digit 0 is never blanked.
- Overflow:
  - oOVF=1.
  - Every digit shows segment g only ("-"), dp per iDP.
  - Blanking is ignored.
- Handshake and timing:
  - iLOAD while busy is ignored, not queued.
  - iLOAD in the same cycle as oDONE is accepted, since oREADY=1 then.
  - Input changes after the accept cycle have no effect.
  - oSEG holds its value between updates; there is no glitching during SHIFT.
- iRST takes priority over iLOAD in the same cycle.

Test Plan:
1. WIDTH=32, DIGITS=6, ACTIVE_LOW=1, decimal load of 1234, iBLANK_LZ=0 -> oDONE at T+34; digits 5..0 = 0,0,1,2,3,4 (byte 0 = 8'hC0 pattern for "0" plus dp off, i.e. 8'b11000000 for digit 5), oOVF=0.
2. Same with iBLANK_LZ=1, value 0 -> digit 0 shows "0" (8'b11000000), digits 1..5 = 8'hFF. Value 1000 -> digits 5,4 = 8'hFF.
3. Hex load 32'h0000BEEF, iDP=6'b000001 -> oDONE at T+2; digits 3..0 = B,E,E,F; digit 0 dp segment on (bit 7 = 0).
4. Decimal overflow:
   - Load 1000000 -> oOVF=1, every digit 8'b10111111.
   - Then load 999999 -> oOVF=0, all digits "9".
5. Reset mid-SHIFT: load 42, assert iRST at T+10 -> no oDONE, oSEG all 8'hFF, oREADY=1 next cycle. A subsequent load of 42 completes normally.
6. Busy and back-to-back loads:
   - iLOAD pulsed at T+5 during SHIFT -> ignored, display shows the first value.
   - iLOAD held high through oDONE -> second conversion accepted in the oDONE cycle.
